// File: rtl/pred_pkg.sv
// Shared widths, condition codes and helpers for the branch-predictor return path.
package pred_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned INSTR_W = 14;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned COND_W  = 2;

    localparam logic [COND_W-1:0] COND_ALWAYS = 2'b00;
    localparam logic [COND_W-1:0] COND_WZ     = 2'b01;
    localparam logic [COND_W-1:0] COND_CY     = 2'b10;
    localparam logic [COND_W-1:0] COND_NCY    = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Only the fields the resolver needs are kept per in-flight prediction.
    typedef struct packed {
        logic              taken;
        logic [COND_W-1:0] cond;
        logic [ADDR_W-1:0] target;
        logic [ADDR_W-1:0] addr;
    } pred_entry_t;

    localparam int unsigned ENTRY_W = $bits(pred_entry_t);

    function automatic logic [COND_W-1:0] branch_cond(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: COND_W];
    endfunction

    function automatic logic branch_taken(input logic [COND_W-1:0] cond,
                                          input logic [DATA_W-1:0] w,
                                          input logic              cy);
        logic t;
        case (cond)
            COND_ALWAYS: t = 1'b1;
            COND_WZ:     t = (w == '0);
            COND_CY:     t = cy;
            default:     t = ~cy;
        endcase
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/predictor_outcome_resolver_if.sv
// Fetch/execute-facing bus of the prediction outcome resolver.
interface predictor_outcome_resolver_if;
    import pred_pkg::*;

    logic               pred_valid;
    logic               pred_ready;
    logic               pred_taken;
    logic [INSTR_W-1:0] pred_branch;
    logic [ADDR_W-1:0]  pred_branch_addr;
    logic               exec_done;
    logic [DATA_W-1:0]  W;
    logic               CY;
    logic               flush;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               update_valid;
    logic [ADDR_W-1:0]  update_addr;
    logic               update_taken;
    logic [CNT_W-1:0]   mispredict_count;
    logic [CNT_W-1:0]   resolved_count;
    logic               underflow_err;

    modport master (
        output pred_valid, pred_taken, pred_branch, pred_branch_addr, exec_done, W, CY,
        input  pred_ready, flush, redirect_addr, update_valid, update_addr, update_taken,
               mispredict_count, resolved_count, underflow_err
    );

    modport slave (
        input  pred_valid, pred_taken, pred_branch, pred_branch_addr, exec_done, W, CY,
        output pred_ready, flush, redirect_addr, update_valid, update_addr, update_taken,
               mispredict_count, resolved_count, underflow_err
    );

endinterface

// File: rtl/pred_fifo.sv
// Circular FIFO of in-flight predictions; clear wins over push/pop in the same cycle.
module pred_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/predictor_outcome_resolver.sv
// Resolves queued branch predictions against execute results, drives flush/redirect and trains the predictor.
module predictor_outcome_resolver
    import pred_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                         clock,
    input logic                         reset_n,
    predictor_outcome_resolver_if.slave bus
);

    localparam int unsigned FC_W = 4;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic              uv_q, uv_d;
    logic [ADDR_W-1:0] ua_q, ua_d;
    logic              ut_q, ut_d;
    logic [CNT_W-1:0]  mc_q, mc_d;
    logic [CNT_W-1:0]  rc_q, rc_d;
    logic              uerr_q, uerr_d;

    logic              fifo_push, fifo_pop, fifo_clear;
    logic              fifo_full, fifo_empty;
    logic              ready;
    logic              actual;
    pred_entry_t       head;
    pred_entry_t       incoming;

    assign ready = (state_q == ST_RUN) & ~fifo_full;

    always_comb begin
        incoming        = '0;
        incoming.taken  = bus.pred_taken;
        incoming.cond   = branch_cond(bus.pred_branch);
        incoming.target = bus.pred_branch[ADDR_W-1:0];
        incoming.addr   = bus.pred_branch_addr;
    end

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (incoming),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign actual = branch_taken(head.cond, bus.W, bus.CY);

    // Next-state, resolution and FIFO control.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        flush_d    = 1'b0;
        redirect_d = '0;
        uv_d       = 1'b0;
        ua_d       = '0;
        ut_d       = 1'b0;
        mc_d       = mc_q;
        rc_d       = rc_q;
        uerr_d     = uerr_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
        case (state_q)
            ST_RUN: begin
                fifo_push = bus.pred_valid & ready;
                if (bus.exec_done) begin
                    if (fifo_empty) begin
                        uerr_d = 1'b1;
                    end else begin
                        uv_d = 1'b1;
                        ua_d = head.addr;
                        ut_d = actual;
                        rc_d = sat_inc(rc_q);
                        if (actual != head.taken) begin
                            // Wrong path: drop the whole queue, including this cycle's push.
                            flush_d    = 1'b1;
                            redirect_d = actual ? head.target : head.addr + ADDR_W'(1);
                            mc_d       = sat_inc(mc_q);
                            fifo_clear = 1'b1;
                            fifo_push  = 1'b0;
                            state_d    = ST_FLUSH;
                            fcnt_d     = FC_W'(FLUSH_CYCLES - 1);
                        end else begin
                            fifo_pop = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) state_d = ST_RUN;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            fcnt_q     <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            uv_q       <= 1'b0;
            ua_q       <= '0;
            ut_q       <= 1'b0;
            mc_q       <= '0;
            rc_q       <= '0;
            uerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            uv_q       <= uv_d;
            ua_q       <= ua_d;
            ut_q       <= ut_d;
            mc_q       <= mc_d;
            rc_q       <= rc_d;
            uerr_q     <= uerr_d;
        end
    end

    assign bus.pred_ready       = ready;
    assign bus.flush            = flush_q;
    assign bus.redirect_addr    = redirect_q;
    assign bus.update_valid     = uv_q;
    assign bus.update_addr      = ua_q;
    assign bus.update_taken     = ut_q;
    assign bus.mispredict_count = mc_q;
    assign bus.resolved_count   = rc_q;
    assign bus.underflow_err    = uerr_q;

endmodule

// File: tb/tb_predictor_outcome_resolver.sv
// Randomized bench for predictor_outcome_resolver against a queue-based outcome model.
module tb_predictor_outcome_resolver;

    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    predictor_outcome_resolver_if bus();

    predictor_outcome_resolver #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit        taken;
        bit [13:0] br;
        bit [10:0] addr;
    } ent_t;

    ent_t      q[$];
    int        fl      = 0;
    bit        started = 0;
    bit        m_flush, m_uv, m_ut, m_uerr;
    bit [10:0] m_redir, m_ua;
    int        m_mc, m_rc;

    function automatic bit actual_dir(bit [13:0] br, bit [15:0] w, bit cy);
        int c;
        c = (int'(br) >> 12) & 3;
        if (c == 0) return 1'b1;
        if (c == 1) return (w == 16'd0);
        if (c == 2) return cy;
        return !cy;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: advances on every rising edge from the inputs present at that edge.
    always @(posedge clock) begin
        bit   rdy;
        bit   act;
        ent_t e;
        ent_t h;
        started = 1'b1;
        if (!reset_n) begin
            q.delete();
            fl = 0; m_flush = 0; m_redir = '0; m_uv = 0; m_ua = '0; m_ut = 0;
            m_mc = 0; m_rc = 0; m_uerr = 0;
        end else begin
            rdy     = (fl == 0) && (q.size() < DEPTH);
            e.taken = bus.pred_taken;
            e.br    = bus.pred_branch;
            e.addr  = bus.pred_branch_addr;
            m_flush = 0; m_uv = 0;
            if (fl > 0) begin
                fl--;
            end else if (bus.exec_done && q.size() == 0) begin
                m_uerr = 1;
                if (bus.pred_valid && rdy) q.push_back(e);
            end else if (bus.exec_done) begin
                h    = q[0];
                act  = actual_dir(h.br, bus.W, bus.CY);
                m_uv = 1; m_ua = h.addr; m_ut = act;
                if (m_rc < 65535) m_rc++;
                if (act != h.taken) begin
                    m_flush = 1;
                    m_redir = act ? h.br[10:0] : 11'((int'(h.addr) + 1) % 2048);
                    if (m_mc < 65535) m_mc++;
                    q.delete();
                    fl = FC;
                end else begin
                    void'(q.pop_front());
                    if (bus.pred_valid && rdy) q.push_back(e);
                end
            end else if (bus.pred_valid && rdy) begin
                q.push_back(e);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            check("pred_ready", 32'(bus.pred_ready), 32'((fl == 0) && (q.size() < DEPTH)));
            check("flush", 32'(bus.flush), 32'(m_flush));
            if (m_flush) check("redirect_addr", 32'(bus.redirect_addr), 32'(m_redir));
            check("update_valid", 32'(bus.update_valid), 32'(m_uv));
            if (m_uv) begin
                check("update_addr", 32'(bus.update_addr), 32'(m_ua));
                check("update_taken", 32'(bus.update_taken), 32'(m_ut));
            end
            check("mispredict_count", 32'(bus.mispredict_count), 32'(m_mc));
            check("resolved_count", 32'(bus.resolved_count), 32'(m_rc));
            check("underflow_err", 32'(bus.underflow_err), 32'(m_uerr));
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_push(input bit t, input bit [13:0] br, input bit [10:0] a);
        bus.pred_valid       = 1'b1;
        bus.pred_taken       = t;
        bus.pred_branch      = br;
        bus.pred_branch_addr = a;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.pred_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.pred_ready) check("ready_timeout", 32'(bus.pred_ready), 32'd1);
    endtask

    initial begin
        bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_branch = '0;
        bus.pred_branch_addr = '0; bus.exec_done = 0; bus.W = '0; bus.CY = 0;

        // 1: reset then idle
        reset_n = 0; tick(); tick(); reset_n = 1;
        repeat (3) tick();
        check("t1_ready", 32'(bus.pred_ready), 32'd1);
        check("t1_flush", 32'(bus.flush), 32'd0);
        check("t1_uv", 32'(bus.update_valid), 32'd0);
        check("t1_mc", 32'(bus.mispredict_count), 32'd0);
        check("t1_rc", 32'(bus.resolved_count), 32'd0);

        // 2: correct always-taken prediction
        drive_push(1, 14'h0123, 11'h040); tick();
        bus.pred_valid = 0; bus.exec_done = 1; bus.W = 16'h1234; bus.CY = 0; tick();
        bus.exec_done = 0;
        check("t2_uv", 32'(bus.update_valid), 32'd1);
        check("t2_ua", 32'(bus.update_addr), 32'h040);
        check("t2_ut", 32'(bus.update_taken), 32'd1);
        check("t2_flush", 32'(bus.flush), 32'd0);

        // 3: W==0 condition mispredicted as not-taken
        drive_push(0, 14'h1050, 11'h010); tick();
        bus.pred_valid = 0; bus.exec_done = 1; bus.W = 16'h0000; tick();
        bus.exec_done = 0;
        check("t3_flush", 32'(bus.flush), 32'd1);
        check("t3_redir", 32'(bus.redirect_addr), 32'h050);
        check("t3_mc", 32'(bus.mispredict_count), 32'd1);
        check("t3_ready0", 32'(bus.pred_ready), 32'd0);
        tick(); check("t3_ready1", 32'(bus.pred_ready), 32'd0);
        tick(); check("t3_ready2", 32'(bus.pred_ready), 32'd1);

        // 4: fall-through wraps at the top of the address space
        drive_push(1, 14'h3200, 11'h7FF); tick();
        bus.pred_valid = 0; bus.exec_done = 1; bus.CY = 1; bus.W = 16'h0005; tick();
        bus.exec_done = 0;
        check("t4_flush", 32'(bus.flush), 32'd1);
        check("t4_redir", 32'(bus.redirect_addr), 32'h000);
        check("t4_mc", 32'(bus.mispredict_count), 32'd2);
        wait_ready();

        // 5: fill, overflow push ignored, mispredict head while pushing, then underflow
        drive_push(0, 14'h0123, 11'h100); tick();
        for (int k = 1; k < 4; k++) begin
            drive_push(1, 14'(k), 11'(12'h100 + k)); tick();
        end
        check("t5_full", 32'(bus.pred_ready), 32'd0);
        drive_push(1, 14'h0aaa, 11'h2aa); tick();
        check("t5_full2", 32'(bus.pred_ready), 32'd0);
        bus.exec_done = 1; tick();
        bus.exec_done = 0; bus.pred_valid = 0;
        check("t5_flush", 32'(bus.flush), 32'd1);
        check("t5_redir", 32'(bus.redirect_addr), 32'h123);
        wait_ready();
        bus.exec_done = 1; tick(); bus.exec_done = 0;
        check("t5_uerr", 32'(bus.underflow_err), 32'd1);
        check("t5_uv", 32'(bus.update_valid), 32'd0);

        // 6: reset during FLUSH, then reset with entries queued
        drive_push(0, 14'h0010, 11'h020); tick();
        drive_push(1, 14'h0011, 11'h021); tick();
        drive_push(1, 14'h0012, 11'h022); tick();
        bus.pred_valid = 0; bus.exec_done = 1; tick(); bus.exec_done = 0;
        check("t6_flush", 32'(bus.flush), 32'd1);
        reset_n = 0; tick(); reset_n = 1;
        check("t6_flush0", 32'(bus.flush), 32'd0);
        check("t6_uv0", 32'(bus.update_valid), 32'd0);
        check("t6_mc0", 32'(bus.mispredict_count), 32'd0);
        check("t6_rc0", 32'(bus.resolved_count), 32'd0);
        check("t6_uerr0", 32'(bus.underflow_err), 32'd0);
        check("t6_ready", 32'(bus.pred_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive_push(1, 14'(k), 11'(k)); tick();
        end
        bus.pred_valid = 0; reset_n = 0; tick(); reset_n = 1;
        bus.exec_done = 1; tick(); bus.exec_done = 0;
        check("t6_empty_uerr", 32'(bus.underflow_err), 32'd1);
        check("t6_empty_uv", 32'(bus.update_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n              = ($urandom_range(0, 299) != 0);
            bus.pred_valid       = ($urandom_range(0, 9) < 6);
            bus.pred_taken       = 1'($urandom);
            bus.pred_branch      = 14'($urandom);
            bus.pred_branch_addr = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom);
            bus.exec_done        = ($urandom_range(0, 9) < 4);
            bus.W                = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            bus.CY               = 1'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
